serial_frame_decoder: RTL and testbench

SERIAL_FRAME_DECODER -- requirements
Module: serial_frame_decoder

---
 rtl/serial_frame_decoder_pkg.sv | 23 ++
 rtl/serial_byte_timer.sv | 49 ++++
 rtl/serial_frame_decoder.sv | 171 +++++++++++++++++
 tb/tb_serial_frame_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_decoder_pkg
// Purpose  : Shared types and constants for the serial frame decoder.
//            - state_e          : decoder FSM state encoding
//            - PAYLOAD_LEN_DEF  : default payload bytes per frame
//            - ADDR_W           : payload RAM address width
// Revision : 1.0  initial release
// ============================================================================
package serial_frame_decoder_pkg;

  localparam int PAYLOAD_LEN_DEF = 32;
  localparam int ADDR_W          = 5;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_STATUS  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage : serial_frame_decoder_pkg
`default_nettype wire

// File: rtl/serial_byte_timer.sv
`default_nettype none
// ============================================================================
// Module   : serial_byte_timer
// Purpose  : Inter-byte idle timer. Counts clocks while not cleared and flags
//            expiry in the cycle the count reaches TIMEOUT_CYCLES idle clocks.
//            A clear in that same cycle suppresses the expiry.
// Ports    : clk_i      in  clock, rising edge
//            rst_n_i    in  asynchronous active-low reset
//            clear_i    in  restart the count (byte strobe or decoder idle)
//            expired_o  out limit reached this cycle with no clear
// Revision : 1.0  initial release
// ============================================================================
module serial_byte_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int                CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]     LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // count_q holds (idle cycles so far - 1); it saturates at LIMIT so the
  // decoder alone decides what happens after expiry.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_q != LIMIT) begin
      count_d = count_q + 1'b1;
    end
  end

  assign expired_o = !clear_i && (count_q == LIMIT);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : serial_byte_timer
`default_nettype wire

// File: rtl/serial_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_decoder
// Purpose  : Decodes byte frames [header][status][PAYLOAD_LEN payload] and
//            writes the payload into a RAM, one registered write per byte.
//            Optional feature macro FRAME_TIMEOUT_EN adds an inter-byte
//            timeout that aborts a stalled frame with frame_error_o.
// Ports    : clk_i, rst_n_i            clock / async active-low reset
//            rx_data_i, new_rx_data_i  received byte and its valid strobe
//            header_byte_i             frame header constant
//            ram_we_o/address_o/data_o payload RAM write port
//            status_o                  status byte of last valid frame
//            frame_valid_o             pulse: complete frame stored
//            frame_error_o             pulse: frame aborted (timeout)
//            busy_o                    decoder not hunting for a header
// Revision : 1.0  initial release
// ============================================================================
module serial_frame_decoder
  import serial_frame_decoder_pkg::*;
#(
  parameter int PAYLOAD_LEN    = PAYLOAD_LEN_DEF,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [7:0]        rx_data_i,
  input  logic              new_rx_data_i,
  input  logic [7:0]        header_byte_i,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_address_o,
  output logic [7:0]        ram_data_o,
  output logic [7:0]        status_o,
  output logic              frame_valid_o,
  output logic              frame_error_o,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PAYLOAD_LEN - 1);

  generate
    if (PAYLOAD_LEN < 1 || PAYLOAD_LEN > 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("serial_frame_decoder: parameter out of range");
    end
  endgenerate

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          shadow_q, shadow_d;
  logic [7:0]          status_q, status_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                err_d;
  logic                timeout;
  logic                is_header;

  assign is_header = (rx_data_i == header_byte_i);

`ifdef FRAME_TIMEOUT_EN
  logic err_q;

  serial_byte_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (new_rx_data_i || (state_q == ST_HUNT)),
    .expired_o (timeout)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign frame_error_o = err_q;
`else
  assign timeout       = 1'b0;
  assign frame_error_o = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    status_d = status_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        if (new_rx_data_i && is_header) begin
          state_d = ST_STATUS;
        end
      end
      ST_STATUS: begin
        // Header-valued bytes here are plain status data, never a resync.
        if (new_rx_data_i) begin
          shadow_d = rx_data_i;
          cnt_d    = '0;
          state_d  = ST_PAYLOAD;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_HUNT;
        end
      end
      ST_PAYLOAD: begin
        if (new_rx_data_i) begin
          we_d   = 1'b1;
          addr_d = cnt_q;
          data_d = rx_data_i;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = ST_DONE;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_HUNT;
        end
      end
      ST_DONE: begin
        // The final write is on the bus this cycle; commit the frame and
        // treat any arriving byte as a header candidate.
        valid_d  = 1'b1;
        status_d = shadow_q;
        cnt_d    = '0;
        state_d  = (new_rx_data_i && is_header) ? ST_STATUS : ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_HUNT;
      cnt_q    <= '0;
      shadow_q <= '0;
      status_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      status_q <= status_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign ram_we_o      = we_q;
  assign ram_address_o = addr_q;
  assign ram_data_o    = data_q;
  assign status_o      = status_q;
  assign frame_valid_o = valid_q;
  assign busy_o        = (state_q != ST_HUNT);

endmodule : serial_frame_decoder
`default_nettype wire

// File: tb/tb_serial_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_decoder
// Purpose  : Self-checking bench for serial_frame_decoder. Expected RAM
//            writes and frame status bytes are queued as stimulus is driven
//            and compared when the decoder produces them. Timeout scenarios
//            run only when FRAME_TIMEOUT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_frame_decoder;

  localparam int PLEN = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       new_rx;
  logic [7:0] header;
  logic       ram_we;
  logic [4:0] ram_addr;
  logic [7:0] ram_data;
  logic [7:0] status;
  logic       fvalid;
  logic       ferror;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int nvalid   = 0;
  int nerror   = 0;

  logic [12:0] wr_q[$];   // {addr, data}
  logic [7:0]  st_q[$];
  logic [7:0]  pl[PLEN];

  serial_frame_decoder #(
    .PAYLOAD_LEN    (PLEN),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .rx_data_i     (rx_data),
    .new_rx_data_i (new_rx),
    .header_byte_i (header),
    .ram_we_o      (ram_we),
    .ram_address_o (ram_addr),
    .ram_data_o    (ram_data),
    .status_o      (status),
    .frame_valid_o (fvalid),
    .frame_error_o (ferror),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (ram_we) begin
      logic [12:0] e;
      chk("write_expected", 32'(wr_q.size() > 0), 32'd1);
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        chk("ram_addr", 32'(ram_addr), 32'(e[12:8]));
        chk("ram_data", 32'(ram_data), 32'(e[7:0]));
      end
    end
    if (fvalid) begin
      nvalid++;
      chk("valid_expected", 32'(st_q.size() > 0), 32'd1);
      if (st_q.size() > 0) chk("status", 32'(status), 32'(st_q.pop_front()));
    end
    if (ferror) nerror++;
  end

  // Called at posedge+1; strobe covers exactly one cycle.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    new_rx  = 1'b1;
    @(posedge clk); #1;
    new_rx  = 1'b0;
  endtask

  task automatic send_payload(input int from, input int to);
    for (int i = from; i < to; i++) begin
      wr_q.push_back({5'(i), pl[i]});
      send_byte(pl[i]);
    end
  endtask

  task automatic send_frame(input logic [7:0] st);
    send_byte(8'hA5);
    send_byte(st);
    send_payload(0, PLEN);
    st_q.push_back(st);
  endtask

  task automatic wait_valid(input int target);
    for (int i = 0; i < 200 && nvalid < target; i++) @(posedge clk);
    #1;
    chk("frame_count", 32'(nvalid), 32'(target));
  endtask

  int early;

  initial begin
    rst_n   = 1'b0;
    new_rx  = 1'b0;
    rx_data = 8'h00;
    header  = 8'hA5;
    repeat (3) @(posedge clk); #1;

    // Reset state
    chk("rst_we",     32'(ram_we),   32'd0);
    chk("rst_addr",   32'(ram_addr), 32'd0);
    chk("rst_data",   32'(ram_data), 32'd0);
    chk("rst_status", 32'(status),   32'd0);
    chk("rst_valid",  32'(fvalid),   32'd0);
    chk("rst_error",  32'(ferror),   32'd0);
    chk("rst_busy",   32'(busy),     32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame 1: incrementing payload
    for (int i = 0; i < PLEN; i++) pl[i] = 8'(i);
    send_frame(8'h3C);
    wait_valid(1);
    chk("status_f1", 32'(status), 32'h3C);
    chk("busy_idle", 32'(busy), 32'd0);

    // Frame 2: leading garbage ignored, random payload
    send_byte(8'h11);
    send_byte(8'h22);
    chk("garbage_busy", 32'(busy), 32'd0);
    for (int i = 0; i < PLEN; i++) pl[i] = 8'($urandom_range(0, 255));
    send_frame(8'h07);
    // Frame 3 header arrives in the DONE cycle of frame 2; A5 is payload data.
    for (int i = 0; i < PLEN; i++) pl[i] = 8'(8'hFF - i);
    pl[5] = 8'hA5;
    send_frame(8'hA5);
    wait_valid(3);
    chk("status_f3", 32'(status), 32'hA5);

    // Reset mid-frame after 20 payload bytes
    send_byte(8'hA5);
    send_byte(8'h44);
    for (int i = 0; i < PLEN; i++) pl[i] = 8'(8'h40 + i);
    send_payload(0, 20);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_status", 32'(status), 32'd0);
    chk("mid_rst_busy",   32'(busy),   32'd0);
    chk("mid_rst_addr",   32'(ram_addr), 32'd0);
    chk("mid_rst_data",   32'(ram_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk); #1;
    chk("no_valid_after_rst", 32'(nvalid), 32'd3);
    send_frame(8'h5A);
    wait_valid(4);
    chk("status_f4", 32'(status), 32'h5A);
    chk("no_error", 32'(nerror), 32'd0);

`ifdef FRAME_TIMEOUT_EN
    // Stall after 10 payload bytes: error exactly at idle cycle 100
    send_byte(8'hA5);
    send_byte(8'h99);
    for (int i = 0; i < PLEN; i++) pl[i] = 8'(8'h80 + i);
    send_payload(0, 10);
    early = 0;
    for (int i = 1; i < 100; i++) begin
      @(posedge clk); #1;
      if (ferror) early++;
    end
    chk("timeout_not_early", 32'(early), 32'd0);
    @(posedge clk); #1;
    chk("timeout_error", 32'(ferror), 32'd1);
    @(posedge clk); #1;
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_status", 32'(status), 32'h5A);
    chk("timeout_count", 32'(nerror), 32'd1);
    send_frame(8'h21);
    wait_valid(5);
    chk("status_after_to", 32'(status), 32'h21);

    // Strobe on the limit cycle wins
    send_byte(8'hA5);
    send_byte(8'h66);
    for (int i = 0; i < PLEN; i++) pl[i] = 8'(8'hC0 + i);
    send_payload(0, 3);
    repeat (99) @(posedge clk); #1;
    send_payload(3, 4);
    repeat (3) @(posedge clk); #1;
    chk("coincident_no_error", 32'(nerror), 32'd1);
    send_payload(4, PLEN);
    st_q.push_back(8'h66);
    wait_valid(6);
    chk("status_coincident", 32'(status), 32'h66);
`endif

    repeat (4) @(posedge clk); #1;
    chk("writes_drained", 32'(wr_q.size()), 32'd0);
    chk("status_drained", 32'(st_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_frame_decoder
`default_nettype wire
